// File: rtl/game_ctrl.sv
// game_ctrl: round timer, pad edge detection and fixed-priority hit arbiter
// for a drum-pad game. Optional pause support is compiled in with the macro
// GAME_PAUSE_EN, which adds the pause_btn input and the PAUSED state.
module game_ctrl #(
  parameter int unsigned CLK_HZ    = 25_000_000,
  parameter int unsigned ROUND_SEC = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
`ifdef GAME_PAUSE_EN
  input  logic       pause_btn,
`endif
  input  logic       kick_btn,
  input  logic       snare_btn,
  input  logic       hat_btn,
  output logic       kick_hit,
  output logic       snare_hit,
  output logic       hat_hit,
  output logic [5:0] timer_seconds,
  output logic [1:0] state,
  output logic [9:0] hit_count
);

  localparam int unsigned PW        = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [5:0] ROUND_LOAD = 6'(ROUND_SEC);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    DONE   = 2'd2,
    PAUSED = 2'd3
  } state_t;

  state_t        st, st_next;
  logic [PW-1:0] presc, presc_next;
  logic [5:0]    timer, timer_next;
  logic [9:0]    count, count_next;
  // Pad vectors are ordered {kick, snare, hat}, i.e. highest priority first.
  logic [2:0]    pend, pend_next;
  logic [2:0]    pad_prev;
  logic          start_prev;
  logic [2:0]    pad_edge;
  logic          start_edge;
  logic          pause_edge;
  logic [2:0]    issue;

  assign pad_edge   = {kick_btn, snare_btn, hat_btn} & ~pad_prev;
  assign start_edge = start & ~start_prev;

  // Edge-detector history; resets high so inputs held through reset give no edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pad_prev   <= '1;
      start_prev <= 1'b1;
    end else begin
      pad_prev   <= {kick_btn, snare_btn, hat_btn};
      start_prev <= start;
    end
  end

`ifdef GAME_PAUSE_EN
  logic pause_prev;

  assign pause_edge = pause_btn & ~pause_prev;

  // Pause button history for its rising-edge detector
  always_ff @(posedge clk) begin
    if (!rst_n) pause_prev <= 1'b1;
    else        pause_prev <= pause_btn;
  end
`else
  assign pause_edge = 1'b0;
`endif

  // State, prescaler, timer, hit counter and pending-bit registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st    <= IDLE;
      presc <= '0;
      timer <= ROUND_LOAD;
      count <= '0;
      pend  <= '0;
    end else begin
      st    <= st_next;
      presc <= presc_next;
      timer <= timer_next;
      count <= count_next;
      pend  <= pend_next;
    end
  end

  // Next-state, round timing, arbitration and pending-bit update
  always_comb begin
    st_next    = st;
    presc_next = presc;
    timer_next = timer;
    count_next = count;
    issue      = '0;

    case (st)
      IDLE: begin
        timer_next = ROUND_LOAD;
        if (start_edge) begin
          st_next    = PLAY;
          presc_next = '0;
          count_next = '0;
        end
      end
      PLAY: begin
        if (presc == PRESC_MAX) begin
          presc_next = '0;
          timer_next = timer - 6'd1;
          if (timer == 6'd1) st_next = DONE;
        end else begin
          presc_next = presc + 1'b1;
        end
        // The final wrap into DONE takes precedence over a pause request;
        // otherwise a pause freezes the count in the cycle it is seen.
        if (st_next != DONE && pause_edge) begin
          st_next    = PAUSED;
          presc_next = presc;
          timer_next = timer;
        end
      end
      DONE: begin
        timer_next = '0;
        if (start_edge) begin
          st_next    = PLAY;
          presc_next = '0;
          timer_next = ROUND_LOAD;
          count_next = '0;
        end
      end
      PAUSED: begin
        if (pause_edge) st_next = PLAY;
      end
    endcase

    // Hits only go out while staying in IDLE or PLAY
    if ((st == IDLE || st == PLAY) && (st_next == IDLE || st_next == PLAY)) begin
      if (pend[2])      issue = 3'b100;
      else if (pend[1]) issue = 3'b010;
      else if (pend[0]) issue = 3'b001;
    end

    if (st == PLAY && issue != '0 && count != 10'h3FF) count_next = count + 10'd1;

    // A fresh edge re-sets a bit being issued in the same cycle, so no hit is lost
    if (st == DONE || st == PAUSED || st_next == DONE || st_next == PAUSED) begin
      pend_next = '0;
    end else begin
      pend_next = (pend & ~issue) | pad_edge;
    end
  end

  assign {kick_hit, snare_hit, hat_hit} = issue;
  assign timer_seconds = timer;
  assign state         = st;
  assign hit_count     = count;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed self-checking bench for game_ctrl. A small round
// (CLK_HZ=10, ROUND_SEC=3) exercises timing, arbitration and reset; a second
// instance with CLK_HZ=5000 exercises hit-counter saturation.
module tb_game_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, kick, snare, hat;
`ifdef GAME_PAUSE_EN
  logic       pause;
`endif
  logic       kick_hit, snare_hit, hat_hit;
  logic [5:0] timer;
  logic [1:0] state;
  logic [9:0] count;
  logic [2:0] hits;

  logic       rst_n2, start2, kick2;
  logic       kick_hit2, snare_hit2, hat_hit2;
  logic [5:0] timer2;
  logic [1:0] state2;
  logic [9:0] count2;

  int checks = 0;
  int errors = 0;

  assign hits = {kick_hit, snare_hit, hat_hit};

  game_ctrl #(.CLK_HZ(10), .ROUND_SEC(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
`ifdef GAME_PAUSE_EN
    .pause_btn     (pause),
`endif
    .kick_btn      (kick),
    .snare_btn     (snare),
    .hat_btn       (hat),
    .kick_hit      (kick_hit),
    .snare_hit     (snare_hit),
    .hat_hit       (hat_hit),
    .timer_seconds (timer),
    .state         (state),
    .hit_count     (count)
  );

  game_ctrl #(.CLK_HZ(5000), .ROUND_SEC(3)) dut_sat (
    .clk           (clk),
    .rst_n         (rst_n2),
    .start         (start2),
`ifdef GAME_PAUSE_EN
    .pause_btn     (1'b0),
`endif
    .kick_btn      (kick2),
    .snare_btn     (1'b0),
    .hat_btn       (1'b0),
    .kick_hit      (kick_hit2),
    .snare_hit     (snare_hit2),
    .hat_hit       (hat_hit2),
    .timer_seconds (timer2),
    .state         (state2),
    .hit_count     (count2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; kick = 1'b0; snare = 1'b0; hat = 1'b0;
`ifdef GAME_PAUSE_EN
    pause = 1'b0;
`endif
    rst_n2 = 1'b0; start2 = 1'b0; kick2 = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_timer", 32'(timer), 32'd3);
    check("rst_count", 32'(count), 32'd0);
    check("rst_hits",  32'(hits),  32'b000);

    // free play in IDLE: hit issued, not counted
    kick = 1'b1; tick();
    check("idle_hit", 32'(hits), 32'b100);
    kick = 1'b0; tick();
    check("idle_hit_off", 32'(hits), 32'b000);
    check("idle_count", 32'(count), 32'd0);

    // round 1: timer sequence, start edge ignored mid-round
    start = 1'b1; tick();
    check("start_state", 32'(state), 32'd1);
    check("start_timer", 32'(timer), 32'd3);
    for (int i = 1; i <= 30; i++) begin
      start = (i == 4);
      tick();
      if (i == 9)  check("timer_p9",  32'(timer), 32'd3);
      if (i == 10) check("timer_p10", 32'(timer), 32'd2);
      if (i == 20) check("timer_p20", 32'(timer), 32'd1);
      if (i == 29) check("state_p29", 32'(state), 32'd1);
      if (i == 30) begin
        check("timer_p30", 32'(timer), 32'd0);
        check("state_p30", 32'(state), 32'd2);
      end
    end

    // round 2: simultaneous edges, then re-set while issuing
    start = 1'b1; tick(); start = 1'b0;
    check("r2_state", 32'(state), 32'd1);
    check("r2_timer", 32'(timer), 32'd3);
    kick = 1'b1; snare = 1'b1; hat = 1'b1; tick();
    check("all_n1", 32'(hits), 32'b100);
    kick = 1'b0; snare = 1'b0; hat = 1'b0; tick();
    check("all_n2", 32'(hits), 32'b010);
    tick();
    check("all_n3", 32'(hits), 32'b001);
    tick();
    check("all_n4", 32'(hits), 32'b000);
    check("all_count", 32'(count), 32'd3);

    kick = 1'b1; snare = 1'b1; tick();
    check("reset_n1", 32'(hits), 32'b100);
    kick = 1'b0; snare = 1'b0; tick();
    check("reset_n2", 32'(hits), 32'b010);
    snare = 1'b1; tick();
    check("reset_n3", 32'(hits), 32'b010);
    snare = 1'b0; tick();
    check("reset_n4", 32'(hits), 32'b000);
    check("reset_count", 32'(count), 32'd6);

    // wait for round end, then pads in DONE are dropped
    for (int i = 0; i < 40 && state != 2'd2; i++) tick();
    check("done_state", 32'(state), 32'd2);
    check("done_timer", 32'(timer), 32'd0);
    check("done_count", 32'(count), 32'd6);
    kick = 1'b1; snare = 1'b1; hat = 1'b1; tick();
    check("done_hits1", 32'(hits), 32'b000);
    kick = 1'b0; snare = 1'b0; hat = 1'b0; tick();
    check("done_hits2", 32'(hits), 32'b000);
    tick();
    check("done_hits3", 32'(hits), 32'b000);
    check("done_hold", 32'(count), 32'd6);
    start = 1'b1; tick(); start = 1'b0;
    check("r3_state", 32'(state), 32'd1);
    check("r3_timer", 32'(timer), 32'd3);
    check("r3_count", 32'(count), 32'd0);

    // reset mid-round with pads rising during reset
    tick(); tick();
    rst_n = 1'b0; kick = 1'b1; snare = 1'b1; hat = 1'b1; tick();
    rst_n = 1'b1;
    check("mrst_state", 32'(state), 32'd0);
    check("mrst_timer", 32'(timer), 32'd3);
    check("mrst_count", 32'(count), 32'd0);
    check("mrst_hits0", 32'(hits),  32'b000);
    tick();
    check("mrst_hits1", 32'(hits), 32'b000);
    tick();
    check("mrst_hits2", 32'(hits), 32'b000);
    kick = 1'b0; snare = 1'b0; hat = 1'b0; tick();

`ifdef GAME_PAUSE_EN
    // pause at timer=2 with 3 prescaler counts already done
    start = 1'b1; tick(); start = 1'b0;
    repeat (10) tick();
    check("pz_timer_pre", 32'(timer), 32'd2);
    repeat (3) tick();
    pause = 1'b1; tick(); pause = 1'b0;
    check("pz_state", 32'(state), 32'd3);
    for (int i = 0; i < 25; i++) begin
      kick  = (i == 2);
      start = (i == 5);
      tick();
      if (i == 2 || i == 3) check("pz_hits", 32'(hits), 32'b000);
    end
    check("pz_hold_state", 32'(state), 32'd3);
    check("pz_hold_timer", 32'(timer), 32'd2);
    pause = 1'b1; tick(); pause = 1'b0;
    check("pz_resume", 32'(state), 32'd1);
    repeat (6) tick();
    check("pz_timer_q7", 32'(timer), 32'd2);
    tick();
    check("pz_timer_q8", 32'(timer), 32'd1);
`endif

    // saturation on the long-round instance
    rst_n2 = 1'b1; tick();
    start2 = 1'b1; tick(); start2 = 1'b0;
    check("sat_state", 32'(state2), 32'd1);
    kick2 = 1'b1; tick();
    check("sat_pulse", 32'(kick_hit2), 32'd1);
    kick2 = 1'b0; tick();
    repeat (999) begin
      kick2 = 1'b1; tick();
      kick2 = 1'b0; tick();
    end
    check("sat_1000", 32'(count2), 32'd1000);
    repeat (30) begin
      kick2 = 1'b1; tick();
      kick2 = 1'b0; tick();
    end
    check("sat_1030", 32'(count2), 32'd1023);
    check("sat_still_play", 32'(state2), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter: CLK_HZ, default 25_000_000, clock cycles per displayed second; legal range >= 2.
REQ-002 Parameter: ROUND_SEC, default 30, round length in seconds; legal range 1..59.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  synchronized level; only its rising edge is used.
REQ-006 kick_btn, snare_btn, hat_btn  input  1 each  synchronized, debounced pad levels; only rising edges are used.
REQ-007 kick_hit, snare_hit, hat_hit  output  1 each  one-cycle hit pulses to the pattern generator.
REQ-008 timer_seconds  output  6  seconds remaining in the round.
REQ-009 state  output  2  IDLE=0, PLAY=1, DONE=2, PAUSED=3.
REQ-010 hit_count  output  10  hits issued during the current round.

Function
REQ-011 Edge detect: a rising edge SHALL be the cycle where the input is 1 and its registered previous value is 0; each input has its own detector.
REQ-012 Pending: each pad SHALL have a pending bit, set on that pad's rising edge, unless the edge arrives in DONE or PAUSED.
REQ-013 Arbiter: at most one hit pulse per cycle, fixed priority kick > snare > hat; the issued pad's pending bit clears in the same cycle.
REQ-014 Latency: a lone edge detected in cycle N SHALL produce its hit pulse in cycle N+1.
REQ-015 Arbiter issue: a pad's pending bit, once set, SHALL stay set until that pad wins arbitration.
REQ-016 Simultaneous set/issue: an edge on a pad whose pending bit is being issued in the same cycle SHALL leave the bit set, so no hit is lost.
REQ-017 Simultaneous edges: edges on all three pads in one cycle SHALL yield kick, snare and hat pulses in three consecutive cycles.
REQ-018 IDLE: timer_seconds = ROUND_SEC; hits are issued (free play) but hit_count does not change.
REQ-019 IDLE -> PLAY on start edge: prescaler = 0, timer_seconds = ROUND_SEC, hit_count = 0.
REQ-020 PLAY: prescaler counts 0..CLK_HZ-1 and wraps; on wrap timer_seconds decrements by 1.
REQ-021 PLAY -> DONE on the wrap that takes timer_seconds from 1 to 0; the state and timer change in the same cycle.
REQ-022 PLAY: each issued hit increments hit_count, saturating at 1023.
REQ-023 PLAY: a start edge SHALL be ignored.
REQ-024 DONE: timer_seconds = 0; all pending bits clear on entry; no hit pulses; hit_count holds.
REQ-025 DONE -> PLAY on start edge, with the same reload as REQ-019.
REQ-026 Hit pulses SHALL never be issued in the cycle of a state transition into DONE or PAUSED.

Reset
REQ-027 While rst_n = 0 at a clock edge, the block SHALL enter the following state: state = IDLE, timer_seconds = ROUND_SEC, hit_count = 0, prescaler = 0, all pending bits clear, all hit outputs 0.
REQ-028 Edge-detector history registers SHALL reset to 1, so inputs held high through reset produce no edge.
REQ-029 Reset mid-round SHALL abort the round immediately; there is no recovery of prior count or timer.

Configuration
REQ-030 Macro GAME_PAUSE_EN: when defined, it adds input pause_btn (1 bit, rising-edge used) and enables state PAUSED.
REQ-031 With GAME_PAUSE_EN, a pause edge in PLAY -> PAUSED; a pause edge in PAUSED -> PLAY.
REQ-032 With GAME_PAUSE_EN, PAUSED freezes the prescaler and timer_seconds, and clears and blocks pending bits.
REQ-033 With GAME_PAUSE_EN, a start edge in PAUSED SHALL be ignored; a pause edge in IDLE or DONE is ignored.
REQ-034 With GAME_PAUSE_EN, PAUSED has the same pause-edge precedence over a simultaneous PLAY->DONE wrap as is given below: the DONE transition wins.
REQ-035 Without GAME_PAUSE_EN: no pause_btn port; state never equals 3; behaviour otherwise identical.

Verification (CLK_HZ=10, ROUND_SEC=3)
REQ-036 Reset, then start edge -> state=1, timer_seconds=3; timer reads 2 at +10 cycles, 1 at +20, 0 with state=2 at +30.
REQ-037 Kick, snare and hat edges in the same PLAY cycle N -> kick_hit at N+1, snare_hit at N+2, hat_hit at N+3; hit_count = 3.
REQ-038 1030 kick edges in PLAY, spaced 2 cycles apart (CLK_HZ raised to 5000) -> hit_count saturates at 1023.
REQ-039 Pad edges in DONE -> no hit pulses; then start edge -> state=1, timer_seconds=3, hit_count=0.
REQ-040 rst_n low for 1 cycle mid-PLAY with pads held high -> IDLE, timer=3, no spurious hits after release.
REQ-041 GAME_PAUSE_EN defined, pause edge at timer_seconds=2 plus 25 wait cycles -> timer stays 2; second pause edge -> timer decrements to 1 after exactly the remaining prescaler count.
